// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: Tuse/Tnew values, MDU latencies and timer states.
package pipe_pkg;

  localparam logic [1:0] T_0    = 2'd0;
  localparam logic [1:0] T_1    = 2'd1;
  localparam logic [1:0] T_2    = 2'd2;
  localparam logic [1:0] T_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_md_busy_timer.sv
// MDU busy timer: holds busy for MULT_CYCLES or DIV_CYCLES after a start.
module md_busy_timer
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES)
                      ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start seen while busy is dropped; the D-stage stall prevents it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = is_div ? CW'(DIV_CYCLES)
                           : CW'(MULT_CYCLES);
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1))
          state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush control: Tuse/Tnew hazards, MDU busy stall and
// a saturating stalled-cycle counter.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs_addr,
  input  logic [4:0]       d_rt_addr,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic             d_is_md,
  input  logic [4:0]       e_wr_addr,
  input  logic [1:0]       e_tnew,
  input  logic [4:0]       m_wr_addr,
  input  logic [1:0]       m_tnew,
  input  logic             e_md_start,
  input  logic             e_md_is_div,
  output logic             stall,
  output logic             pc_en,
  output logic             d_reg_we,
  output logic             e_reg_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic rs_hz, rt_hz, md_hz;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (e_md_start),
    .is_div (e_md_is_div),
    .busy   (md_busy)
  );

  // $zero never hazards; T_NONE marks an operand that is not read.
  always_comb begin
    rs_hz = (d_rs_addr != 5'd0) && (d_tuse_rs != T_NONE)
         && (((d_rs_addr == e_wr_addr) && (d_tuse_rs < e_tnew))
          || ((d_rs_addr == m_wr_addr) && (d_tuse_rs < m_tnew)));
    rt_hz = (d_rt_addr != 5'd0) && (d_tuse_rt != T_NONE)
         && (((d_rt_addr == e_wr_addr) && (d_tuse_rt < e_tnew))
          || ((d_rt_addr == m_wr_addr) && (d_tuse_rt < m_tnew)));
    md_hz = d_is_md && (md_busy || e_md_start);
  end

  assign stall       = rs_hz | rt_hz | md_hz;
  assign pc_en       = ~stall;
  assign d_reg_we    = ~stall;
  assign e_reg_flush = stall;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with a cycle-indexed reference model.
module tb_pipe_stall_ctrl;

  localparam int CNT_W = 4;
  localparam int MULT_N = 5;
  localparam int DIV_N = 10;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] d_rs_addr, d_rt_addr, e_wr_addr, m_wr_addr;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic d_is_md, e_md_start, e_md_is_div;
  logic stall, pc_en, d_reg_we, e_reg_flush, md_busy;
  logic [CNT_W-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipe_stall_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .d_rs_addr    (d_rs_addr),
    .d_rt_addr    (d_rt_addr),
    .d_tuse_rs    (d_tuse_rs),
    .d_tuse_rt    (d_tuse_rt),
    .d_is_md      (d_is_md),
    .e_wr_addr    (e_wr_addr),
    .e_tnew       (e_tnew),
    .m_wr_addr    (m_wr_addr),
    .m_tnew       (m_tnew),
    .e_md_start   (e_md_start),
    .e_md_is_div  (e_md_is_div),
    .stall        (stall),
    .pc_en        (pc_en),
    .d_reg_we     (d_reg_we),
    .e_reg_flush  (e_reg_flush),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: the MDU is busy in the N cycles after its start
  // cycle; the counter is min(stalled cycles since reset, CMAX).
  int cyc = 0;
  int md_t0 = -1;
  int md_n = 0;
  int m_cnt = 0;
  bit started = 0;

  function automatic bit m_busy(int c);
    return (md_t0 >= 0) && (c > md_t0) && (c <= md_t0 + md_n);
  endfunction

  function automatic bit hz(logic [4:0] a, logic [1:0] tu);
    if (a == 5'd0 || tu == 2'd3) return 1'b0;
    return (a == e_wr_addr && int'(tu) < int'(e_tnew))
        || (a == m_wr_addr && int'(tu) < int'(m_tnew));
  endfunction

  function automatic bit m_stall();
    return hz(d_rs_addr, d_tuse_rs) || hz(d_rt_addr, d_tuse_rt)
        || (d_is_md && (m_busy(cyc) || e_md_start));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      md_t0 = -1;
      m_cnt = 0;
    end else begin
      if (m_stall() && m_cnt < CMAX) m_cnt++;
      if (e_md_start && !m_busy(cyc)) begin
        md_t0 = cyc;
        md_n = e_md_is_div ? DIV_N : MULT_N;
      end
    end
    cyc++;
    started = 1;
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("m_stall", int'(stall), int'(m_stall()));
      chk("m_pc_en", int'(pc_en), int'(!m_stall()));
      chk("m_d_we", int'(d_reg_we), int'(!m_stall()));
      chk("m_flush", int'(e_reg_flush), int'(m_stall()));
      chk("m_busy", int'(md_busy), int'(m_busy(cyc)));
      chk("m_cnt", int'(stall_cycles), m_cnt);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    d_rs_addr = 0; d_rt_addr = 0;
    d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_is_md = 0;
    e_wr_addr = 0; e_tnew = 0;
    m_wr_addr = 0; m_tnew = 0;
    e_md_start = 0; e_md_is_div = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clr();
    nxt();
    nxt();
    reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    clr();
    nxt();
    mid();
    chk("rst_stall", int'(stall), 0);
    chk("rst_pc_en", int'(pc_en), 1);
    chk("rst_d_we", int'(d_reg_we), 1);
    chk("rst_flush", int'(e_reg_flush), 0);
    chk("rst_busy", int'(md_busy), 0);
    chk("rst_cnt", int'(stall_cycles), 0);
    nxt();
    reset = 0;

    // load-use on rs
    e_wr_addr = 5; e_tnew = 2; d_rs_addr = 5; d_tuse_rs = 0;
    mid();
    chk("lu_stall", int'(stall), 1);
    chk("lu_pc_en", int'(pc_en), 0);
    chk("lu_d_we", int'(d_reg_we), 0);
    chk("lu_flush", int'(e_reg_flush), 1);
    nxt();
    e_tnew = 0;
    mid();
    chk("lu_clear", int'(stall), 0);
    nxt();

    // $zero and unused operand
    clr();
    e_tnew = 2;
    d_tuse_rs = 0;
    mid();
    chk("zero_reg", int'(stall), 0);
    nxt();
    clr();
    e_wr_addr = 7; e_tnew = 2; d_rt_addr = 7; d_tuse_rt = 3;
    mid();
    chk("rt_unused", int'(stall), 0);
    nxt();

    // M-stage hazard on rt
    clr();
    m_wr_addr = 8; m_tnew = 1; d_rt_addr = 8; d_tuse_rt = 0;
    mid();
    chk("m_hz", int'(stall), 1);
    nxt();
    d_tuse_rt = 1;
    mid();
    chk("m_hz_clr", int'(stall), 0);
    nxt();

    // mult followed by mflo held in D
    do_reset();
    e_md_start = 1; e_md_is_div = 0; d_is_md = 1;
    mid();
    chk("mul_t0_stall", int'(stall), 1);
    chk("mul_t0_busy", int'(md_busy), 0);
    nxt();
    e_md_start = 0;
    for (int i = 1; i <= MULT_N; i++) begin
      mid();
      chk("mul_busy", int'(md_busy), 1);
      chk("mul_stall", int'(stall), 1);
      nxt();
    end
    mid();
    chk("mul_done_busy", int'(md_busy), 0);
    chk("mul_done_stall", int'(stall), 0);
    chk("mul_cnt", int'(stall_cycles), 6);
    nxt();

    // div interrupted by reset
    do_reset();
    e_md_start = 1; e_md_is_div = 1; d_is_md = 1;
    nxt();
    e_md_start = 0;
    nxt();
    nxt();
    nxt();
    reset = 1;
    mid();
    chk("div_c4_busy", int'(md_busy), 1);
    nxt();
    reset = 0;
    d_is_md = 0;
    mid();
    chk("div_rst_busy", int'(md_busy), 0);
    chk("div_rst_cnt", int'(stall_cycles), 0);
    nxt();

    // counter saturation
    do_reset();
    e_wr_addr = 3; e_tnew = 2; d_rs_addr = 3; d_tuse_rs = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 15) begin
        mid();
        chk("sat_at15", int'(stall_cycles), 15);
      end
      nxt();
    end
    clr();
    mid();
    chk("sat_end", int'(stall_cycles), 15);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
